reorder_buffer_mc: RTL and testbench
====================================

REORDER_BUFFER_MC -- requirements
Module: reorder_buffer_mc

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning entry-index width; depth = 2^IDX_W, every entry usable.
REQ-002 SHALL have parameter WB_N, default 2, meaning number of writeback channels.
REQ-003 SHALL have parameter COMMIT_W, default 2, legal values 1 or 2, meaning maximum retirements per cycle.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_in  input  1  clock, rising edge; rst_n_in  input  1  reset, 0 = reset.
REQ-005 rdy_in  input  1  global enable; low = hold all state.
REQ-006 issue_valid, issue_is_br, issue_pred_br  input  1 each; issue_rd  input  5; issue_pc  input  32.
REQ-007 issue_idx  output  IDX_W  slot the next issue takes; full  output  1  no free slot.
REQ-008 wb_valid  input  WB_N; wb_idx  input  WB_N*IDX_W; wb_val  input  WB_N*32; wb_br_taken  input  WB_N; wb_br_pc  input  WB_N*32; channel k occupies slice k.
REQ-009 rs1_idx, rs2_idx  input  IDX_W; rs1_ready, rs2_ready  output  1; rs1_val, rs2_val  output  32.
REQ-010 commit_valid  output  COMMIT_W; commit_rd  output  COMMIT_W*5; commit_idx  output  COMMIT_W*IDX_W; commit_val  output  COMMIT_W*32; slot 0 is oldest.
REQ-011 clr_out  output  1  flush pulse; alter_pc  output  32  redirect target.
REQ-012 pr_valid, pr_taken  output  1; pr_pc  output  32  predictor update.

Function
REQ-013 Head/tail pointers SHALL be IDX_W+1 bits; the extra bit is the wrap bit; empty when equal, full when equal in index bits but different in wrap bit.
REQ-014 Issue SHALL be accepted when issue_valid && !full && !clr_out; the entry is written at tail with ready = 0; tail increments; full SHALL NOT consider same-cycle commits.
REQ-015 A writeback on channel k SHALL set ready, value, taken and target of entry wb_idx[k]; if two channels name the same index, the higher k wins.
REQ-016 Lookups SHALL be combinational from stored entry state.
REQ-017 Commit slot 0 SHALL retire the head entry when it is valid and ready; slot 1, when COMMIT_W = 2, SHALL retire head+1 only when slot 0 retires, head+1 is valid and ready, neither entry is a branch, and slot 0 is not a mispredict.
REQ-018 A mispredict SHALL be defined as pred_br != taken; on retiring one, the cycle after SHALL have clr_out = 1 and alter_pc = pc+4 if predicted taken, else the stored target.
REQ-019 In the clr_out cycle all entries SHALL be invalidated, head = tail = 0, issue/writeback/commit ignored; clr_out SHALL last exactly one cycle.
REQ-020 A retired branch SHALL produce, the next cycle, a one-cycle pr_valid pulse with its pc and taken.
REQ-021 Commit outputs SHALL be registered, one-cycle latency after the retire decision; commit_valid bits SHALL be one-cycle pulses.
REQ-022 With rdy_in low, no pointer or entry SHALL change and all pulse outputs SHALL deassert.
REQ-023 Issue and commit SHALL happen in the same cycle without conflict, including with wrap-around at index 2^IDX_W-1 -> 0.

Reset
REQ-024 With rst_n_in low, the following SHALL be cleared immediately regardless of clock: head, tail, all valid bits, commit_valid, clr_out, pr_valid; data outputs SHALL be 0.
REQ-025 Reset deasserted mid-operation SHALL leave the buffer empty, with the first issue landing at index 0.

Configuration
REQ-026 Macro ROB_WB_BYPASS_EN defined: a lookup whose index matches a same-cycle valid writeback SHALL return ready = 1 with that value (higher channel wins).
REQ-027 Macro ROB_WB_BYPASS_EN undefined: lookups SHALL reflect only stored state, so the writeback is visible the following cycle.

Verification
REQ-028 Fill: 16 issues with no writeback -> full = 1 after the 16th, a 17th issue is rejected, issue_idx holds at 0.
REQ-029 Dual commit: entries 0 and 1 (non-branch) both written back -> next cycle commit_valid = 2'b11, commit_idx = {1,0}.
REQ-030 Mispredict: branch at pc 0x100, pred 0, wb taken to 0x200, younger entries ready -> clr_out = 1 with alter_pc = 0x200, younger entries never commit, and a pr_valid pulse with pr_pc = 0x100 and pr_taken = 1.
REQ-031 Wrap: 40 issue/writeback/commit cycles at depth 16 -> in-order commit_idx 0..15,0.. with no loss.
REQ-032 Bypass: wb ch1 idx 3 val 0x55 with rs1_idx = 3 in the same cycle -> rs1_ready = 1 and rs1_val = 0x55 with the macro; rs1_ready = 0 without it.
REQ-033 rst_n_in pulsed low mid-cycle while half full -> outputs clear without a clock edge, and the first issue after release gets index 0.

Source files
------------

// File: rtl/reorder_buffer_mc.sv
// Reorder buffer: in-order issue, out-of-order writeback, up to COMMIT_W in-order retirements per cycle.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks to the rs1/rs2 lookups.
module reorder_buffer_mc #(
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned WB_N     = 2,
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      issue_valid,
  input  logic                      issue_is_br,
  input  logic                      issue_pred_br,
  input  logic [4:0]                issue_rd,
  input  logic [31:0]               issue_pc,
  output logic [IDX_W-1:0]          issue_idx,
  output logic                      full,
  input  logic [WB_N-1:0]           wb_valid,
  input  logic [WB_N*IDX_W-1:0]     wb_idx,
  input  logic [WB_N*32-1:0]        wb_val,
  input  logic [WB_N-1:0]           wb_br_taken,
  input  logic [WB_N*32-1:0]        wb_br_pc,
  input  logic [IDX_W-1:0]          rs1_idx,
  input  logic [IDX_W-1:0]          rs2_idx,
  output logic                      rs1_ready,
  output logic                      rs2_ready,
  output logic [31:0]               rs1_val,
  output logic [31:0]               rs2_val,
  output logic [COMMIT_W-1:0]       commit_valid,
  output logic [COMMIT_W*5-1:0]     commit_rd,
  output logic [COMMIT_W*IDX_W-1:0] commit_idx,
  output logic [COMMIT_W*32-1:0]    commit_val,
  output logic                      clr_out,
  output logic [31:0]               alter_pc,
  output logic                      pr_valid,
  output logic                      pr_taken,
  output logic [31:0]               pr_pc
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [IDX_W:0]       head, tail;
  logic [DEPTH-1:0]     ent_valid, ent_ready, ent_br, ent_pred, ent_taken;
  logic [4:0]           ent_rd  [DEPTH];
  logic [31:0]          ent_pc  [DEPTH];
  logic [31:0]          ent_val [DEPTH];
  logic [31:0]          ent_tgt [DEPTH];

  logic [IDX_W-1:0]     h0, h1;
  logic [IDX_W-1:0]     slot [COMMIT_W];
  logic [COMMIT_W-1:0]  retire;
  logic [IDX_W:0]       n_ret;
  logic                 active, accept, mis0;

  always_comb begin
    full      = (head[IDX_W] != tail[IDX_W]) && (head[IDX_W-1:0] == tail[IDX_W-1:0]);
    issue_idx = tail[IDX_W-1:0];
    h0        = head[IDX_W-1:0];
    h1        = IDX_W'(h0 + 1'b1);
    for (int unsigned s = 0; s < COMMIT_W; s++) slot[s] = IDX_W'(h0 + IDX_W'(s));
  end

  // Retirement is decided purely from stored entry state, never from same-cycle writebacks.
  always_comb begin
    active    = rdy_in && !clr_out;
    accept    = active && issue_valid && !full;
    mis0      = ent_br[h0] && (ent_pred[h0] != ent_taken[h0]);
    retire    = '0;
    retire[0] = active && ent_valid[h0] && ent_ready[h0];
    if (COMMIT_W == 2)
      retire[COMMIT_W-1] = retire[0] && ent_valid[h1] && ent_ready[h1] &&
                           !ent_br[h0] && !ent_br[h1] && !mis0;
    n_ret = (IDX_W+1)'(retire[0]);
    if (COMMIT_W == 2) n_ret = n_ret + (IDX_W+1)'(retire[COMMIT_W-1]);
  end

  always_comb begin
    rs1_ready = ent_ready[rs1_idx];
    rs1_val   = ent_val[rs1_idx];
    rs2_ready = ent_ready[rs2_idx];
    rs2_val   = ent_val[rs2_idx];
`ifdef ROB_WB_BYPASS_EN
    for (int unsigned k = 0; k < WB_N; k++) begin
      if (wb_valid[k] && wb_idx[k*IDX_W +: IDX_W] == rs1_idx) begin
        rs1_ready = 1'b1;
        rs1_val   = wb_val[k*32 +: 32];
      end
      if (wb_valid[k] && wb_idx[k*IDX_W +: IDX_W] == rs2_idx) begin
        rs2_ready = 1'b1;
        rs2_val   = wb_val[k*32 +: 32];
      end
    end
`endif
  end

  // A mispredict flushes at the retiring edge, so the clr_out cycle already sees an empty buffer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      ent_ready <= '0;
      ent_br    <= '0;
      ent_pred  <= '0;
      ent_taken <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_rd[i]  <= '0;
        ent_pc[i]  <= '0;
        ent_val[i] <= '0;
        ent_tgt[i] <= '0;
      end
    end else if (active) begin
      if (retire[0] && mis0) begin
        head      <= '0;
        tail      <= '0;
        ent_valid <= '0;
        ent_ready <= '0;
      end else begin
        for (int unsigned k = 0; k < WB_N; k++) begin
          if (wb_valid[k]) begin
            ent_ready[wb_idx[k*IDX_W +: IDX_W]] <= 1'b1;
            ent_val[wb_idx[k*IDX_W +: IDX_W]]   <= wb_val[k*32 +: 32];
            ent_taken[wb_idx[k*IDX_W +: IDX_W]] <= wb_br_taken[k];
            ent_tgt[wb_idx[k*IDX_W +: IDX_W]]   <= wb_br_pc[k*32 +: 32];
          end
        end
        if (accept) begin
          ent_valid[issue_idx] <= 1'b1;
          ent_ready[issue_idx] <= 1'b0;
          ent_br[issue_idx]    <= issue_is_br;
          ent_pred[issue_idx]  <= issue_pred_br;
          ent_taken[issue_idx] <= 1'b0;
          ent_rd[issue_idx]    <= issue_rd;
          ent_pc[issue_idx]    <= issue_pc;
          tail                 <= tail + 1'b1;
        end
        for (int unsigned s = 0; s < COMMIT_W; s++)
          if (retire[s]) ent_valid[slot[s]] <= 1'b0;
        head <= head + n_ret;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commit_valid <= '0;
      commit_rd    <= '0;
      commit_idx   <= '0;
      commit_val   <= '0;
      clr_out      <= 1'b0;
      alter_pc     <= '0;
      pr_valid     <= 1'b0;
      pr_taken     <= 1'b0;
      pr_pc        <= '0;
    end else begin
      commit_valid <= retire;
      clr_out      <= retire[0] && mis0;
      pr_valid     <= retire[0] && ent_br[h0];
      for (int unsigned s = 0; s < COMMIT_W; s++) begin
        if (retire[s]) begin
          commit_rd[s*5 +: 5]          <= ent_rd[slot[s]];
          commit_idx[s*IDX_W +: IDX_W] <= slot[s];
          commit_val[s*32 +: 32]       <= ent_val[slot[s]];
        end
      end
      if (retire[0]) begin
        alter_pc <= ent_pred[h0] ? ent_pc[h0] + 32'd4 : ent_tgt[h0];
        pr_pc    <= ent_pc[h0];
        pr_taken <= ent_taken[h0];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc with a queue-based reference model checked every cycle.
module tb_reorder_buffer_mc;
  localparam int IDX_W = 4, WB_N = 2, COMMIT_W = 2, DEPTH = 16;

  logic                      clk_in = 1'b0, rst_n_in, rdy_in;
  logic                      issue_valid, issue_is_br, issue_pred_br;
  logic [4:0]                issue_rd;
  logic [31:0]               issue_pc;
  logic [IDX_W-1:0]          issue_idx;
  logic                      full;
  logic [WB_N-1:0]           wb_valid, wb_br_taken;
  logic [WB_N*IDX_W-1:0]     wb_idx;
  logic [WB_N*32-1:0]        wb_val, wb_br_pc;
  logic [IDX_W-1:0]          rs1_idx, rs2_idx;
  logic                      rs1_ready, rs2_ready;
  logic [31:0]               rs1_val, rs2_val;
  logic [COMMIT_W-1:0]       commit_valid;
  logic [COMMIT_W*5-1:0]     commit_rd;
  logic [COMMIT_W*IDX_W-1:0] commit_idx;
  logic [COMMIT_W*32-1:0]    commit_val;
  logic                      clr_out, pr_valid, pr_taken;
  logic [31:0]               alter_pc, pr_pc;

  reorder_buffer_mc #(.IDX_W(IDX_W), .WB_N(WB_N), .COMMIT_W(COMMIT_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_is_br(issue_is_br), .issue_pred_br(issue_pred_br),
    .issue_rd(issue_rd), .issue_pc(issue_pc), .issue_idx(issue_idx), .full(full),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val), .wb_br_taken(wb_br_taken),
    .wb_br_pc(wb_br_pc), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_ready(rs1_ready),
    .rs2_ready(rs2_ready), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_idx(commit_idx),
    .commit_val(commit_val), .clr_out(clr_out), .alter_pc(alter_pc),
    .pr_valid(pr_valid), .pr_taken(pr_taken), .pr_pc(pr_pc)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0, n_fail = 0, n_commits = 0;
  bit chk_en = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order queue of entry indices plus per-slot attributes.
  int          q[$];
  int          m_tail;
  logic [4:0]  m_rd   [DEPTH];
  logic [31:0] m_pc   [DEPTH];
  logic [31:0] m_val  [DEPTH];
  logic [31:0] m_tgt  [DEPTH];
  bit          m_br   [DEPTH];
  bit          m_pred [DEPTH];
  bit          m_ready[DEPTH];
  bit          m_taken[DEPTH];
  logic [1:0]  e_cv;
  int          e_cidx[2];
  logic [4:0]  e_crd [2];
  logic [31:0] e_cval[2];
  bit          e_clr, e_prv, e_prt;
  logic [31:0] e_alt, e_prpc;

  function automatic void mreset();
    q.delete();
    m_tail = 0;
    for (int i = 0; i < DEPTH; i++) m_ready[i] = 0;
    e_cv = 0; e_clr = 0; e_prv = 0;
  endfunction

  function automatic bit in_q(int idx);
    foreach (q[i]) if (q[i] == idx) return 1;
    return 0;
  endfunction

  task automatic mstep();
    int n; bit mis; int h;
    if (!rdy_in || e_clr) begin
      e_cv = 0; e_clr = 0; e_prv = 0;
      return;
    end
    n = 0; mis = 0;
    if (q.size() > 0 && m_ready[q[0]]) begin
      h = q[0];
      n = 1;
      mis = m_br[h] && (m_pred[h] != m_taken[h]);
      if (q.size() > 1 && m_ready[q[1]] && !m_br[h] && !m_br[q[1]]) n = 2;
    end
    e_cv = 0;
    for (int s = 0; s < n; s++) begin
      e_cv[s] = 1; e_cidx[s] = q[s]; e_crd[s] = m_rd[q[s]]; e_cval[s] = m_val[q[s]];
    end
    e_prv = (n > 0) && m_br[q[0]];
    if (e_prv) begin e_prpc = m_pc[q[0]]; e_prt = m_taken[q[0]]; end
    e_clr = mis;
    if (mis) e_alt = m_pred[q[0]] ? m_pc[q[0]] + 4 : m_tgt[q[0]];
    for (int k = 0; k < WB_N; k++) begin
      if (wb_valid[k]) begin
        h = int'(wb_idx[k*IDX_W +: IDX_W]);
        m_ready[h] = 1; m_val[h] = wb_val[k*32 +: 32];
        m_taken[h] = wb_br_taken[k]; m_tgt[h] = wb_br_pc[k*32 +: 32];
      end
    end
    if (issue_valid && q.size() < DEPTH) begin
      q.push_back(m_tail);
      m_ready[m_tail] = 0; m_taken[m_tail] = 0;
      m_br[m_tail] = issue_is_br; m_pred[m_tail] = issue_pred_br;
      m_rd[m_tail] = issue_rd; m_pc[m_tail] = issue_pc;
      m_tail = (m_tail + 1) % DEPTH;
    end
    for (int s = 0; s < n; s++) void'(q.pop_front());
    if (mis) begin
      q.delete(); m_tail = 0;
      for (int i = 0; i < DEPTH; i++) m_ready[i] = 0;
    end
  endtask

  always @(posedge clk_in) if (rst_n_in) mstep();

  task automatic chk_lookup(string name, logic [IDX_W-1:0] idx, logic rdy, logic [31:0] val);
    bit r; logic [31:0] v;
    if (!in_q(int'(idx))) return;
    r = m_ready[idx]; v = m_val[idx];
`ifdef ROB_WB_BYPASS_EN
    for (int k = 0; k < WB_N; k++)
      if (wb_valid[k] && wb_idx[k*IDX_W +: IDX_W] == idx) begin r = 1; v = wb_val[k*32 +: 32]; end
`endif
    chk({name, "_ready"}, rdy, r);
    if (r) chk({name, "_val"}, val, v);
  endtask

  always @(negedge clk_in) begin
    if (chk_en && rst_n_in) begin
      chk("issue_idx", issue_idx, m_tail);
      chk("full", full, q.size() == DEPTH);
      chk("commit_valid", commit_valid, e_cv);
      for (int s = 0; s < 2; s++) begin
        if (e_cv[s] && commit_valid[s]) begin
          chk("commit_idx", commit_idx[s*IDX_W +: IDX_W], e_cidx[s]);
          chk("commit_rd", commit_rd[s*5 +: 5], e_crd[s]);
          chk("commit_val", commit_val[s*32 +: 32], e_cval[s]);
        end
        if (commit_valid[s]) n_commits++;
      end
      chk("clr_out", clr_out, e_clr);
      if (e_clr) chk("alter_pc", alter_pc, e_alt);
      chk("pr_valid", pr_valid, e_prv);
      if (e_prv) begin
        chk("pr_pc", pr_pc, e_prpc);
        chk("pr_taken", pr_taken, e_prt);
      end
      #2;
      if (rst_n_in) begin
        chk_lookup("rs1", rs1_idx, rs1_ready, rs1_val);
        chk_lookup("rs2", rs2_idx, rs2_ready, rs2_val);
      end
    end
  end

  task automatic nxt();
    @(negedge clk_in);
    issue_valid = 0; wb_valid = '0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [31:0] pc, input logic br, input logic pred);
    issue_valid = 1; issue_rd = rd; issue_pc = pc; issue_is_br = br; issue_pred_br = pred;
  endtask

  task automatic do_wb(input int k, input logic [IDX_W-1:0] idx, input logic [31:0] val,
                       input logic taken, input logic [31:0] tgt);
    wb_valid[k] = 1; wb_idx[k*IDX_W +: IDX_W] = idx; wb_val[k*32 +: 32] = val;
    wb_br_taken[k] = taken; wb_br_pc[k*32 +: 32] = tgt;
  endtask

  task automatic chk_cleared(string tag);
    chk({tag, "_commit_valid"}, commit_valid, 0);
    chk({tag, "_commit_val"}, commit_val[31:0], 0);
    chk({tag, "_commit_idx"}, commit_idx, 0);
    chk({tag, "_clr_out"}, clr_out, 0);
    chk({tag, "_alter_pc"}, alter_pc, 0);
    chk({tag, "_pr_valid"}, pr_valid, 0);
    chk({tag, "_pr_pc"}, pr_pc, 0);
    chk({tag, "_issue_idx"}, issue_idx, 0);
    chk({tag, "_full"}, full, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n_in = 0; rdy_in = 1; issue_valid = 0; issue_is_br = 0; issue_pred_br = 0;
    issue_rd = '0; issue_pc = '0; wb_valid = '0; wb_idx = '0; wb_val = '0;
    wb_br_taken = '0; wb_br_pc = '0; rs1_idx = '0; rs2_idx = '0;
    mreset();
    #1 chk_cleared("reset");
    repeat (2) @(negedge clk_in);
    rst_n_in = 1; chk_en = 1;

    // Fill to capacity, then attempt a 17th issue.
    for (int i = 0; i < 16; i++) begin
      nxt(); do_issue(5'(i), 32'h1000 + 32'(4*i), 0, 0);
    end
    nxt();
    chk("fill_full", full, 1);
    chk("fill_issue_idx", issue_idx, 0);
    do_issue(5'd31, 32'hdead, 0, 0);
    nxt();
    chk("fill17_full", full, 1);
    chk("fill17_issue_idx", issue_idx, 0);

    // Dual commit of entries 0 and 1.
    do_wb(0, 0, 32'ha0, 0, 0); do_wb(1, 1, 32'ha1, 0, 0);
    nxt(); nxt();
    chk("dual_commit_valid", commit_valid, 2'b11);
    chk("dual_commit_idx", commit_idx, {4'd1, 4'd0});
    chk("dual_commit_rd", commit_rd, {5'd1, 5'd0});
    chk("dual_commit_val1", commit_val[63:32], 32'ha1);
    for (int i = 2; i < 16; i += 2) begin
      do_wb(0, 4'(i), 32'hb0 + 32'(i), 0, 0); do_wb(1, 4'(i+1), 32'hb1 + 32'(i), 0, 0);
      rs1_idx = 4'(i);
      nxt();
    end
    repeat (10) nxt();
    chk("drain_commits", n_commits, 16);
    chk("drain_full", full, 0);

    // Mispredicted branch at 0x100, actually taken to 0x200.
    base = n_commits;
    do_issue(5'd1, 32'h100, 1, 0); nxt();
    do_issue(5'd2, 32'h104, 0, 0); nxt();
    do_issue(5'd3, 32'h108, 0, 0); nxt();
    do_wb(0, 1, 32'h11, 0, 0); do_wb(1, 2, 32'h22, 0, 0); nxt();
    do_wb(0, 0, 32'h0, 1, 32'h200); nxt();
    nxt();
    chk("mis_clr_out", clr_out, 1);
    chk("mis_alter_pc", alter_pc, 32'h200);
    chk("mis_pr_valid", pr_valid, 1);
    chk("mis_pr_pc", pr_pc, 32'h100);
    chk("mis_pr_taken", pr_taken, 1);
    chk("mis_commit_valid", commit_valid, 2'b01);
    do_issue(5'd9, 32'h900, 0, 0);
    nxt();
    chk("mis_clr_one_cycle", clr_out, 0);
    chk("mis_issue_idx", issue_idx, 0);
    repeat (3) nxt();
    chk("mis_younger_dropped", n_commits - base, 1);

    // Wrap: steady issue/writeback/commit stream across index 15 -> 0.
    base = n_commits;
    for (int i = 0; i < 40; i++) begin
      nxt();
      do_issue(5'(i % 32), 32'h2000 + 32'(4*i), 0, 0);
      if (i > 0) begin
        do_wb(0, 4'((i-1) % 16), 32'h3000 + 32'(i-1), 0, 0);
        rs1_idx = 4'((i-1) % 16);
      end
    end
    nxt(); do_wb(0, 4'd7, 32'h3000 + 32'd39, 0, 0);
    repeat (5) nxt();
    chk("wrap_commits", n_commits - base, 40);
    chk("wrap_issue_idx", issue_idx, 8);

    // Leave eight entries pending, then reset asynchronously mid-cycle.
    for (int i = 0; i < 10; i++) begin
      nxt(); do_issue(5'(i), 32'h4000 + 32'(4*i), 0, 0);
      if (i == 2) do_wb(0, 4'd8, 32'h48, 0, 0);
      if (i == 3) do_wb(0, 4'd9, 32'h49, 0, 0);
    end
    repeat (3) nxt();
    chk("half_issue_idx", issue_idx, 2);
    @(posedge clk_in); #3;
    rst_n_in = 0;
    mreset();
    #1 chk_cleared("async_reset");
    @(negedge clk_in);
    rst_n_in = 1;
    nxt();
    chk("post_reset_issue_idx", issue_idx, 0);
    for (int i = 0; i < 4; i++) begin
      do_issue(5'(10+i), 32'h5000 + 32'(4*i), 0, 0); nxt();
    end
    chk("post_reset_four", issue_idx, 4);

    // Same-cycle writeback visibility on lookup; channel 1 must win.
    do_wb(0, 4'd3, 32'h11, 0, 0); do_wb(1, 4'd3, 32'h55, 0, 0);
    rs1_idx = 4'd3; rs2_idx = 4'd2;
    #2;
`ifdef ROB_WB_BYPASS_EN
    chk("bypass_rs1_ready", rs1_ready, 1);
    chk("bypass_rs1_val", rs1_val, 32'h55);
`else
    chk("bypass_rs1_ready", rs1_ready, 0);
`endif
    chk("bypass_rs2_ready", rs2_ready, 0);
    nxt(); #2;
    chk("stored_rs1_ready", rs1_ready, 1);
    chk("stored_rs1_val", rs1_val, 32'h55);

    // Global stall: issue and writeback must be ignored.
    base = n_commits;
    rdy_in = 0;
    do_wb(0, 4'd0, 32'h77, 0, 0); do_issue(5'd20, 32'h6000, 0, 0); nxt();
    do_wb(0, 4'd0, 32'h77, 0, 0); do_issue(5'd21, 32'h6004, 0, 0); nxt();
    chk("stall_issue_idx", issue_idx, 4);
    chk("stall_commit_valid", commit_valid, 0);
    rdy_in = 1;
    do_wb(0, 4'd0, 32'h70, 0, 0); do_wb(1, 4'd1, 32'h71, 0, 0); nxt();
    do_wb(0, 4'd2, 32'h72, 0, 0); nxt();
    repeat (4) nxt();
    chk("final_commits", n_commits - base, 4);
    chk("final_full", full, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
